// File: rtl/sys_defs.sv
// Shared FU/complete-stage types and the per-FU result buffer depth.
package sys_defs;

  localparam int NUM_FU_SLOTS = 8;
  localparam int FU_CB_DEPTH  = 2;
  localparam int PR_WIDTH     = 6;

  // Bit i belongs to FU slot i: 0 is alu_1, 7 is branch.
  typedef logic [NUM_FU_SLOTS-1:0] FU_STATE_PACKET;

  typedef struct packed {
    logic [PR_WIDTH-1:0] dest_pr;
    logic [31:0]         dest_value;
    logic                if_take_branch;
  } FU_COMPLETE_PACKET;

endpackage

// File: rtl/fu_result_fifo.sv
// One FU result slot: small FIFO with a grant-pending bit that delays the pop one cycle.
module fu_result_fifo
  import sys_defs::*;
#(
  parameter int DEPTH = FU_CB_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push_valid,
  input  FU_COMPLETE_PACKET push_data,
  input  logic              c_stall,
  input  logic              squash,
  output logic              ready,
  output logic              finish,
  output FU_COMPLETE_PACKET head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  FU_COMPLETE_PACKET mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     cnt;
  logic              pend;
  logic              grant;
  logic              push;

  assign ready  = (cnt < CW'(DEPTH));
  // The in-flight head is already owned by complete_stage, so it is not offered again.
  assign finish = ((cnt - CW'(pend)) != '0) & ~squash;
  assign grant  = finish & ~c_stall;
  assign push   = push_valid & ready & ~squash;
  assign head   = (cnt != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      pend   <= 1'b0;
    end else if (squash) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      pend   <= 1'b0;
    end else begin
      pend <= grant;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pend) rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt + CW'(push) - CW'(pend);
    end
  end

endmodule

// File: rtl/fu_complete_buffer.sv
// Per-FU result buffers feeding complete_stage.
// Optional FU_CB_OVERFLOW_CHECK_EN adds sticky overflow_err and a saturating overflow_cnt.
module fu_complete_buffer
  import sys_defs::*;
#(
  parameter int DEPTH  = FU_CB_DEPTH,
  parameter int NUM_FU = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  FU_STATE_PACKET                 fu_valid,
  input  FU_COMPLETE_PACKET [NUM_FU-1:0] fu_result,
  output FU_STATE_PACKET                 fu_ready,
  input  FU_STATE_PACKET                 fu_c_stall,
  input  logic                           squash,
  output FU_STATE_PACKET                 fu_finish,
  output FU_COMPLETE_PACKET [NUM_FU-1:0] fu_c_in
`ifdef FU_CB_OVERFLOW_CHECK_EN
  ,
  output logic                           overflow_err,
  output logic [15:0]                    overflow_cnt
`endif
);

  generate
    for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_slot
      fu_result_fifo #(
        .DEPTH(DEPTH)
      ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push_valid(fu_valid[gi]),
        .push_data (fu_result[gi]),
        .c_stall   (fu_c_stall[gi]),
        .squash    (squash),
        .ready     (fu_ready[gi]),
        .finish    (fu_finish[gi]),
        .head      (fu_c_in[gi])
      );
    end
  endgenerate

`ifdef FU_CB_OVERFLOW_CHECK_EN
  logic overflow_hit;
  assign overflow_hit = |(fu_valid & ~fu_ready);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow_err <= 1'b0;
      overflow_cnt <= '0;
    end else if (overflow_hit) begin
      overflow_err <= 1'b1;
      if (overflow_cnt != 16'hFFFF) overflow_cnt <= overflow_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fu_complete_buffer.sv
// Bench for fu_complete_buffer: directed scenarios plus a random run against a queue model.
// Overflow outputs are checked when FU_CB_OVERFLOW_CHECK_EN is defined.
module tb_fu_complete_buffer;
  import sys_defs::*;

  localparam int NUM   = 8;
  localparam int DEPTH = FU_CB_DEPTH;

  logic                        clock = 1'b0;
  logic                        reset;
  FU_STATE_PACKET              fu_valid;
  FU_COMPLETE_PACKET [NUM-1:0] fu_result;
  FU_STATE_PACKET              fu_ready;
  FU_STATE_PACKET              fu_c_stall;
  logic                        squash;
  FU_STATE_PACKET              fu_finish;
  FU_COMPLETE_PACKET [NUM-1:0] fu_c_in;
`ifdef FU_CB_OVERFLOW_CHECK_EN
  logic                        overflow_err;
  logic [15:0]                 overflow_cnt;
`endif

  int checks = 0;
  int errors = 0;

  fu_complete_buffer #(.DEPTH(DEPTH), .NUM_FU(NUM)) dut (
    .clock     (clock),
    .reset     (reset),
    .fu_valid  (fu_valid),
    .fu_result (fu_result),
    .fu_ready  (fu_ready),
    .fu_c_stall(fu_c_stall),
    .squash    (squash),
    .fu_finish (fu_finish),
    .fu_c_in   (fu_c_in)
`ifdef FU_CB_OVERFLOW_CHECK_EN
    ,
    .overflow_err(overflow_err),
    .overflow_cnt(overflow_cnt)
`endif
  );

  always #5 clock = ~clock;

  function automatic FU_COMPLETE_PACKET mk(input logic [PR_WIDTH-1:0] pr, input logic [31:0] v,
                                           input logic tb);
    mk.dest_pr        = pr;
    mk.dest_value     = v;
    mk.if_take_branch = tb;
  endfunction

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drive(input FU_STATE_PACKET v, input FU_STATE_PACKET s, input logic sq);
    fu_valid   = v;
    fu_c_stall = s;
    squash     = sq;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(8'h00, 8'h00, 1'b0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    checks++; if (fu_ready !== 8'hFF) begin errors++; $display("FAIL reset_ready: got %h expected ff", fu_ready); end
    checks++; if (fu_finish !== 8'h00) begin errors++; $display("FAIL reset_finish: got %h expected 00", fu_finish); end
    checks++; if (fu_c_in !== '0) begin errors++; $display("FAIL reset_c_in: got %h expected 0", fu_c_in); end
    $display("test_reset done");
  endtask

  task automatic test_single_push();
    FU_COMPLETE_PACKET pa;
    pa = mk(PR_WIDTH'(5), 32'h1234, 1'b0);
    fu_result[0] = pa;
    drive(8'h01, 8'h00, 1'b0);
    tick();
    drive(8'h00, 8'h00, 1'b0);
    checks++; if (fu_finish[0] !== 1'b1) begin errors++; $display("FAIL single_finish_c1: got %b expected 1", fu_finish[0]); end
    tick();
    checks++; if (fu_c_in[0].dest_pr !== PR_WIDTH'(5)) begin errors++; $display("FAIL single_dest_pr_c2: got %0d expected 5", fu_c_in[0].dest_pr); end
    checks++; if (fu_c_in[0].dest_value !== 32'h1234) begin errors++; $display("FAIL single_value_c2: got %h expected 1234", fu_c_in[0].dest_value); end
    checks++; if (fu_finish[0] !== 1'b0) begin errors++; $display("FAIL single_finish_c2: got %b expected 0", fu_finish[0]); end
    tick();
    checks++; if (fu_finish[0] !== 1'b0 || fu_c_in[0] !== '0) begin errors++; $display("FAIL single_empty_c3: finish %b c_in %h expected 0/0", fu_finish[0], fu_c_in[0]); end
    $display("test_single_push done");
  endtask

  task automatic test_stall_full();
    FU_COMPLETE_PACKET pa, pb, pc;
    pa = mk(PR_WIDTH'(11), 32'hAAAA_0001, 1'b0);
    pb = mk(PR_WIDTH'(12), 32'hBBBB_0002, 1'b1);
    pc = mk(PR_WIDTH'(13), 32'hCCCC_0003, 1'b0);
    fu_result[3] = pa;
    drive(8'h08, 8'h08, 1'b0);
    tick();
    fu_result[3] = pb;
    drive(8'h08, 8'h08, 1'b0);
    checks++; if (fu_ready[3] !== 1'b1) begin errors++; $display("FAIL full_ready_c1: got %b expected 1", fu_ready[3]); end
    tick();
    fu_result[3] = pc;
    drive(8'h08, 8'h08, 1'b0);
    checks++; if (fu_ready[3] !== 1'b0) begin errors++; $display("FAIL full_ready_c2: got %b expected 0", fu_ready[3]); end
    tick();
`ifdef FU_CB_OVERFLOW_CHECK_EN
    checks++; if (overflow_err !== 1'b1 || overflow_cnt !== 16'd1) begin errors++; $display("FAIL full_overflow: err %b cnt %0d expected 1/1", overflow_err, overflow_cnt); end
`endif
    drive(8'h00, 8'h00, 1'b0);
    checks++; if (fu_finish[3] !== 1'b1 || fu_c_in[3] !== pa) begin errors++; $display("FAIL full_head_c3: finish %b c_in %h expected 1/%h", fu_finish[3], fu_c_in[3], pa); end
    tick();
    checks++; if (fu_c_in[3] !== pa || fu_ready[3] !== 1'b0) begin errors++; $display("FAIL full_pop_a: c_in %h ready %b expected %h/0", fu_c_in[3], fu_ready[3], pa); end
    tick();
    checks++; if (fu_c_in[3] !== pb || fu_ready[3] !== 1'b1) begin errors++; $display("FAIL full_pop_b: c_in %h ready %b expected %h/1", fu_c_in[3], fu_ready[3], pb); end
    tick();
    checks++; if (fu_c_in[3] !== '0 || fu_finish[3] !== 1'b0) begin errors++; $display("FAIL full_dropped: c_in %h finish %b expected 0/0", fu_c_in[3], fu_finish[3]); end
    $display("test_stall_full done");
  endtask

  task automatic test_back_to_back();
    FU_COMPLETE_PACKET pa, pb;
    pa = mk(PR_WIDTH'(21), 32'h0000_7A7A, 1'b1);
    pb = mk(PR_WIDTH'(22), 32'h0000_7B7B, 1'b0);
    fu_result[7] = pa;
    drive(8'h80, 8'h80, 1'b0);
    tick();
    fu_result[7] = pb;
    drive(8'h80, 8'h80, 1'b0);
    tick();
    drive(8'h00, 8'h00, 1'b0);
    checks++; if (fu_finish[7] !== 1'b1) begin errors++; $display("FAIL b2b_finish_1: got %b expected 1", fu_finish[7]); end
    tick();
    checks++; if (fu_finish[7] !== 1'b1 || fu_c_in[7] !== pa) begin errors++; $display("FAIL b2b_entry_a: finish %b c_in %h expected 1/%h", fu_finish[7], fu_c_in[7], pa); end
    tick();
    checks++; if (fu_finish[7] !== 1'b0 || fu_c_in[7] !== pb) begin errors++; $display("FAIL b2b_entry_b: finish %b c_in %h expected 0/%h", fu_finish[7], fu_c_in[7], pb); end
    tick();
    $display("test_back_to_back done");
  endtask

  task automatic test_push_pop_same();
    FU_COMPLETE_PACKET pa, pb;
    pa = mk(PR_WIDTH'(31), 32'h2222_0A0A, 1'b0);
    pb = mk(PR_WIDTH'(32), 32'h2222_0B0B, 1'b1);
    fu_result[2] = pa;
    drive(8'h04, 8'h00, 1'b0);
    tick();
    drive(8'h00, 8'h00, 1'b0);
    tick();
    fu_result[2] = pb;
    drive(8'h04, 8'h00, 1'b0);
    checks++; if (fu_c_in[2] !== pa) begin errors++; $display("FAIL pp_head_a: got %h expected %h", fu_c_in[2], pa); end
    tick();
    drive(8'h00, 8'h04, 1'b0);
    checks++; if (fu_c_in[2] !== pb || fu_ready[2] !== 1'b1 || fu_finish[2] !== 1'b1) begin errors++; $display("FAIL pp_head_b: c_in %h ready %b finish %b expected %h/1/1", fu_c_in[2], fu_ready[2], fu_finish[2], pb); end
    tick();
    drive(8'h00, 8'h00, 1'b0);
    tick();
    tick();
    checks++; if (fu_c_in[2] !== '0) begin errors++; $display("FAIL pp_drained: got %h expected 0", fu_c_in[2]); end
    $display("test_push_pop_same done");
  endtask

  task automatic test_squash();
    FU_COMPLETE_PACKET p0, p1, p4, p7;
    p0 = mk(PR_WIDTH'(40), 32'h4000_0000, 1'b0);
    p1 = mk(PR_WIDTH'(41), 32'h4100_0000, 1'b0);
    p4 = mk(PR_WIDTH'(44), 32'h4400_0000, 1'b1);
    p7 = mk(PR_WIDTH'(47), 32'h4700_0000, 1'b1);
    fu_result[0] = p0;
    fu_result[4] = p4;
    fu_result[7] = p7;
    drive(8'h91, 8'hFF, 1'b0);
    tick();
    drive(8'h00, 8'hEF, 1'b0);
    tick();
    fu_result[1] = p1;
    drive(8'h02, 8'hFF, 1'b1);
    checks++; if (fu_finish !== 8'h00) begin errors++; $display("FAIL squash_finish: got %h expected 00", fu_finish); end
    checks++; if (fu_c_in[4] !== p4 || fu_c_in[0] !== p0) begin errors++; $display("FAIL squash_heads: c_in4 %h c_in0 %h expected %h/%h", fu_c_in[4], fu_c_in[0], p4, p0); end
    tick();
    drive(8'h00, 8'h00, 1'b0);
    checks++; if (fu_ready !== 8'hFF || fu_finish !== 8'h00) begin errors++; $display("FAIL squash_after: ready %h finish %h expected ff/00", fu_ready, fu_finish); end
    checks++; if (fu_c_in !== '0) begin errors++; $display("FAIL squash_empty: got %h expected 0", fu_c_in); end
    $display("test_squash done");
  endtask

  task automatic test_async_reset();
    fu_result[0] = mk(PR_WIDTH'(50), 32'h5, 1'b0);
    fu_result[1] = mk(PR_WIDTH'(51), 32'h6, 1'b1);
    drive(8'h03, 8'hFF, 1'b0);
    tick();
    drive(8'h03, 8'hFF, 1'b0);
    tick();
    drive(8'h00, 8'hFF, 1'b0);
    checks++; if (fu_ready[1:0] !== 2'b00) begin errors++; $display("FAIL areset_filled: ready %b expected 00", fu_ready[1:0]); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (fu_ready !== 8'hFF || fu_finish !== 8'h00) begin errors++; $display("FAIL areset_ctrl: ready %h finish %h expected ff/00", fu_ready, fu_finish); end
    checks++; if (fu_c_in !== '0) begin errors++; $display("FAIL areset_c_in: got %h expected 0", fu_c_in); end
    @(negedge clock);
    reset = 1'b1;
    drive(8'h00, 8'h00, 1'b0);
    $display("test_async_reset done");
  endtask

  task automatic test_random();
    FU_COMPLETE_PACKET q[NUM][$];
    bit pm[NUM];
    FU_STATE_PACKET er, ef;
    FU_COMPLETE_PACKET [NUM-1:0] ec;
`ifdef FU_CB_OVERFLOW_CHECK_EN
    logic ov_e = 1'b0;
    logic [15:0] ov_c = '0;
`endif
    for (int i = 0; i < NUM; i++) pm[i] = 1'b0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NUM; i++)
        fu_result[i] = mk(PR_WIDTH'($urandom), $urandom, 1'($urandom));
      fu_valid   = 8'($urandom);
      fu_c_stall = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      squash     = ($urandom_range(0, 24) == 0);
      #1;
      for (int i = 0; i < NUM; i++) begin
        er[i] = (q[i].size() < DEPTH);
        ef[i] = !squash && (q[i].size() > (pm[i] ? 1 : 0));
        ec[i] = (q[i].size() != 0) ? q[i][0] : '0;
      end
      checks++; if (fu_ready !== er) begin errors++; $display("FAIL rand_ready cyc %0d: got %h expected %h", n, fu_ready, er); end
      checks++; if (fu_finish !== ef) begin errors++; $display("FAIL rand_finish cyc %0d: got %h expected %h", n, fu_finish, ef); end
      checks++; if (fu_c_in !== ec) begin errors++; $display("FAIL rand_c_in cyc %0d: got %h expected %h", n, fu_c_in, ec); end
`ifdef FU_CB_OVERFLOW_CHECK_EN
      checks++; if (overflow_err !== ov_e || overflow_cnt !== ov_c) begin errors++; $display("FAIL rand_overflow cyc %0d: err %b cnt %0d expected %b/%0d", n, overflow_err, overflow_cnt, ov_e, ov_c); end
      if (|(fu_valid & ~er)) begin
        ov_e = 1'b1;
        if (ov_c != 16'hFFFF) ov_c++;
      end
`endif
      for (int i = 0; i < NUM; i++) begin
        if (squash) begin
          q[i].delete();
          pm[i] = 1'b0;
        end else begin
          if (pm[i]) void'(q[i].pop_front());
          if (fu_valid[i] && er[i]) q[i].push_back(fu_result[i]);
          pm[i] = ef[i] && !fu_c_stall[i];
        end
      end
      tick();
    end
    $display("test_random done");
  endtask

  initial begin
    reset      = 1'b0;
    fu_valid   = '0;
    fu_c_stall = '0;
    squash     = 1'b0;
    fu_result  = '0;
    @(negedge clock);
    test_reset();
    test_single_push();
    test_stall_full();
    test_back_to_back();
    test_push_pop_same();
    test_squash();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fu_complete_buffer.md
# fu_complete_buffer

Per-functional-unit result buffer between the eight FUs (ALU_1 … branch) and `complete_stage`. It captures each FU's finished result, holds it under complete-hazard back-pressure (`fu_c_stall`), and presents `fu_finish` / `fu_c_in` with the one-cycle grant-to-consume skew that `complete_stage` requires. On branch recovery it squashes all buffered results.

## Interface
- `DEPTH`, 2: entries per FU slot; ≥2, power of two.
- `NUM_FU`, 8: number of FU slots; index 7 is branch, index 0 is alu_1.

Ports:
- `clock`  in  1  — system clock.
- `reset`  in  1  — asynchronous, active-low reset.
- `fu_valid`  in  FU_STATE_PACKET  — FU i produces a result this cycle.
- `fu_result`  in  FU_COMPLETE_PACKET [7:0]  — result packets from the FUs.
- `fu_ready`  out  FU_STATE_PACKET  — slot i can accept a result this cycle.
- `fu_c_stall`  in  FU_STATE_PACKET  — from `complete_stage`; same-cycle grant refusal.
- `squash`  in  1  — branch-recovery flush.
- `fu_finish`  out  FU_STATE_PACKET  — to `complete_stage`; slot i requests completion.
- `fu_c_in`  out  FU_COMPLETE_PACKET [7:0]  — head packet of each slot; all-zero when the slot is empty.

## Operation
- Each slot is a FIFO of `DEPTH` packets with count `cnt[i]` (0..DEPTH) and a `pend[i]` bit (head granted last cycle, consumed this cycle).
- Push: `fu_valid[i] & fu_ready[i]` writes `fu_result[i]` at the tail.
- `fu_ready[i] = (cnt[i] < DEPTH)`, registered-state only; no combinational path from `fu_c_stall` or the pop.
- Request: `fu_finish[i] = (cnt[i] - pend[i] != 0) & ~squash`; only entries beyond the in-flight one are offered.
- Grant: `grant[i] = fu_finish[i] & ~fu_c_stall[i]`; `pend[i] <= grant[i]`.
- Pop: when `pend[i]` is 1, the head is shown on `fu_c_in[i]` this cycle and is removed at the clock edge.
- Simultaneous push and pop on the same slot: `cnt` unchanged, FIFO order preserved.
- `fu_c_in[i]` is the head packet when `cnt[i] != 0`; otherwise all-zero (dest_pr 0, dest_value 0, if_take_branch 0).
- Squash: at the next edge all `cnt` and `pend` clear. A push in the squash cycle is discarded. A pending head consumed in the squash cycle is still shown on `fu_c_in` that cycle.
- FIFO pointers wrap modulo `DEPTH`.

## Timing
- Reset (asserted low, async): `cnt = 0`, `pend = 0`, pointers 0. Then `fu_ready = 8'hFF`, `fu_finish = 0`, `fu_c_in` all-zero.
- Push in cycle N means `fu_finish[i]` rises in N+1.
- Grant in N means the packet is on `fu_c_in[i]` in N+1 and is popped at the end of N+1.
- Back-to-back grants on one slot sustain 1 result/cycle when `cnt ≥ 2`.
- A full slot drops `fu_ready` in the cycle after the filling push. It re-asserts in the cycle after the pop edge.
- Reset deassertion mid-operation needs no recovery sequence. All state is already cleared.

## Configuration
- `FU_CB_OVERFLOW_CHECK_EN` defined:
  - Adds output `overflow_err` (1 bit, sticky, reset 0) and a 16-bit saturating `overflow_cnt`.
  - Both update when `fu_valid[i] & ~fu_ready[i]` for any i.
  - The offending packet is still dropped.
- Undefined: those ports and logic are absent. Pushes into a full slot are silently ignored.

## Structure
- The shared package (sys_defs) provides `FU_STATE_PACKET`, `FU_COMPLETE_PACKET`, and a new constant `FU_CB_DEPTH` (default 2).
- Sub-module `fu_result_fifo` holds one slot:
  - FIFO storage, `cnt`, `pend`, and the push/pop/squash logic.
  - It is instantiated `NUM_FU` times by a generate loop.
- The top level only fans out per-FU signals.

## Test plan
- Reset low mid-stream with slots holding 2 entries → `fu_ready = 8'hFF`, `fu_finish = 0`, and `fu_c_in` all-zero immediately, asynchronously.
- Push alu_1 {dest_pr 5, value 32'h1234} in cycle 0 with no stall → `fu_finish[0] = 1` in cycle 1. In cycle 2 `fu_c_in[0].dest_pr = 5`. In cycle 3 the slot is empty and `fu_finish[0] = 0`.
- Push to slot 3 in cycles 0 and 1 with `fu_c_stall[3] = 1` → `fu_ready[3] = 0` from cycle 2. A push in cycle 2 is dropped (with the macro, `overflow_err = 1`). Release the stall → the two packets come out in order.
- Slot 7 holds 2 entries with continuous grants → `fu_finish[7]` stays high for 2 cycles. `fu_c_in[7]` shows entry A then entry B in consecutive cycles.
- Push and pop on slot 2 in the same cycle with `cnt = 1` → `cnt` stays 1 and the new packet becomes head.
- `squash` with slots 0, 4, and 7 occupied and `pend[4] = 1` → `fu_finish = 0` that cycle and `fu_c_in[4]` still shows the pending packet. Next cycle all slots are empty and `fu_ready = 8'hFF`.
